// File: rtl/execute_cycle_if.sv
// ID/EX -> EX bundle plus the EX/MEM outputs and fetch redirect of the execute stage.
// master: the side that drives decoded operands/controls and consumes results.
// slave:  the execute stage itself.
interface execute_cycle_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    // ID/EX inputs
    logic [XLEN-1:0]       RD1_E;
    logic [XLEN-1:0]       RD2_E;
    logic [XLEN-1:0]       ImmExtE;
    logic [XLEN-1:0]       PCE;
    logic [XLEN-1:0]       PCPlus4E;
    logic [REG_ADDR_W-1:0] RdE;
    logic                  RegWriteE;
    logic                  MemWriteE;
    logic                  JumpE;
    logic                  jalrE;
    logic                  BranchE;
    logic                  ALUSrcE;
    logic [2:0]            ALUControlE;
    logic [1:0]            ResultSrcE;
    // hazard unit / writeback
    logic [1:0]            ForwardAE;
    logic [1:0]            ForwardBE;
    logic [XLEN-1:0]       ResultW;
    // fetch redirect
    logic                  PCSrcE;
    logic [XLEN-1:0]       PCTargetE;
    // EX/MEM register
    logic [XLEN-1:0]       ALUResultM;
    logic [XLEN-1:0]       WriteDataM;
    logic [XLEN-1:0]       PCPlus4M;
    logic [REG_ADDR_W-1:0] RdM;
    logic                  RegWriteM;
    logic                  MemWriteM;
    logic [1:0]            ResultSrcM;

    modport master (
        output RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, RdE,
        output RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE,
        output ALUControlE, ResultSrcE, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE,
        input  ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM
    );

    modport slave (
        input  RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, RdE,
        input  RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE,
        input  ALUControlE, ResultSrcE, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE,
        output ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM
    );
endinterface

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and
// target generation, and the EX/MEM pipeline register feeding memory.
module execute_cycle #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    execute_cycle_if.slave ex
);

    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_SLTU = 3'b110,
        ALU_SLL  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       write_data;
        logic [XLEN-1:0]       pc_plus4;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_write;
        logic [1:0]            result_src;
    } ex_mem_t;

    ex_mem_t         ex_mem_q;
    ex_mem_t         ex_mem_d;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] jalr_sum;
    logic            zero;
    alu_op_e         alu_op;

    // Code 11 is unused by the hazard unit and falls back to the register file value.
    // The MEM source is the EX/MEM register output, i.e. the pre-edge value.
    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                                input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] wb,
                                                input logic [XLEN-1:0] mem);
        case (sel)
            FWD_WB:  return wb;
            FWD_MEM: return mem;
            default: return rf;
        endcase
    endfunction

    // Operand selection: forwarded rs1/rs2, then immediate override for B.
    always_comb begin
        src_a      = fwd_mux(ex.ForwardAE, ex.RD1_E, ex.ResultW, ex_mem_q.alu_result);
        write_data = fwd_mux(ex.ForwardBE, ex.RD2_E, ex.ResultW, ex_mem_q.alu_result);
        src_b      = ex.ALUSrcE ? ex.ImmExtE : write_data;
    end

    assign alu_op = alu_op_e'(ex.ALUControlE);

    // ALU: all arithmetic wraps, compares yield a zero-extended 0/1.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_SLL:  alu_result = src_a << src_b[4:0];
            default:  alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    // Redirect: jalr targets rs1+imm with bit 0 cleared, everything else is PC-relative.
    // Combinational so fetch sees the redirect in the same cycle.
    always_comb begin
        jalr_sum     = src_a + ex.ImmExtE;
        ex.PCSrcE    = ex.JumpE | ex.jalrE | (ex.BranchE & zero);
        ex.PCTargetE = ex.jalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (ex.PCE + ex.ImmExtE);
    end

    // Next EX/MEM contents from the current instruction.
    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.alu_result = alu_result;
        ex_mem_d.write_data = write_data;
        ex_mem_d.pc_plus4   = ex.PCPlus4E;
        ex_mem_d.rd         = ex.RdE;
        ex_mem_d.reg_write  = ex.RegWriteE;
        ex_mem_d.mem_write  = ex.MemWriteE;
        ex_mem_d.result_src = ex.ResultSrcE;
    end

    // EX/MEM register: advances every cycle, reset inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst) ex_mem_q <= '0;
        else     ex_mem_q <= ex_mem_d;
    end

    assign ex.ALUResultM = ex_mem_q.alu_result;
    assign ex.WriteDataM = ex_mem_q.write_data;
    assign ex.PCPlus4M   = ex_mem_q.pc_plus4;
    assign ex.RdM        = ex_mem_q.rd;
    assign ex.RegWriteM  = ex_mem_q.reg_write;
    assign ex.MemWriteM  = ex_mem_q.mem_write;
    assign ex.ResultSrcM = ex_mem_q.result_src;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed table, then random vectors
// against an arithmetic reference model.
module tb_execute_cycle;

    logic clk = 1'b0;
    logic rst = 1'b0;

    execute_cycle_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

    execute_cycle #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] rd1, rd2, imm, pc, pcp4, resw;
        logic [4:0]  rd;
        logic        regw, memw, jump, jalr, branch, alusrc;
        logic [2:0]  ctl;
        logic [1:0]  rsrc, fa, fb;
        logic        exp_pcsrc;
        logic [31:0] exp_tgt, exp_alu, exp_wd;
    } vec_t;

    localparam longint MOD = 64'h1_0000_0000;

    int          n_vec = 0;
    int          n_chk = 0;
    int          miscompares = 0;
    logic [31:0] m_alu = 32'h0;   // model's view of ALUResultM
    vec_t        tbl[$];

    function automatic vec_t blank();
        vec_t v;
        v.rst = 0; v.rd1 = 0; v.rd2 = 0; v.imm = 0; v.pc = 0; v.pcp4 = 0; v.resw = 0;
        v.rd = 0; v.regw = 0; v.memw = 0; v.jump = 0; v.jalr = 0; v.branch = 0;
        v.alusrc = 0; v.ctl = 0; v.rsrc = 0; v.fa = 0; v.fb = 0;
        v.exp_pcsrc = 0; v.exp_tgt = 0; v.exp_alu = 0; v.exp_wd = 0;
        return v;
    endfunction

    function automatic vec_t op(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_alu, input logic [31:0] exp_wd);
        vec_t v = blank();
        v.ctl = ctl; v.rd1 = a; v.rd2 = b; v.regw = 1; v.rd = 5'd3;
        v.pcp4 = 32'h4; v.exp_alu = exp_alu; v.exp_wd = exp_wd;
        return v;
    endfunction

    function automatic longint sgn(input longint x);
        return (x >= 64'h8000_0000) ? x - MOD : x;
    endfunction

    // Reference ALU from plain integer arithmetic on 0..2^32-1 values.
    function automatic logic [31:0] ref_alu(input logic [2:0] ctl, input logic [31:0] a32,
                                            input logic [31:0] b32);
        longint a = longint'(a32);
        longint b = longint'(b32);
        longint r;
        case (ctl)
            3'd0: r = (a + b) % MOD;
            3'd1: r = (a + MOD - b) % MOD;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sgn(a) < sgn(b)) ? 1 : 0;
            3'd6: r = (a < b) ? 1 : 0;
            default: r = (a * (longint'(1) << (b % 32))) % MOD;
        endcase
        return r[31:0];
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                         input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return rf;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    // Drive one instruction after the falling edge, check redirect, then check EX/MEM after the edge.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst;
        bus.RD1_E = v.rd1; bus.RD2_E = v.rd2; bus.ImmExtE = v.imm; bus.PCE = v.pc;
        bus.PCPlus4E = v.pcp4; bus.RdE = v.rd; bus.RegWriteE = v.regw; bus.MemWriteE = v.memw;
        bus.JumpE = v.jump; bus.jalrE = v.jalr; bus.BranchE = v.branch; bus.ALUSrcE = v.alusrc;
        bus.ALUControlE = v.ctl; bus.ResultSrcE = v.rsrc; bus.ForwardAE = v.fa;
        bus.ForwardBE = v.fb; bus.ResultW = v.resw;
        #1;
        n_vec++;
        chk("PCSrcE", idx, {31'b0, bus.PCSrcE}, {31'b0, v.exp_pcsrc});
        chk("PCTargetE", idx, bus.PCTargetE, v.exp_tgt);
        @(posedge clk);
        #1;
        chk("ALUResultM", idx, bus.ALUResultM, v.rst ? 32'h0 : v.exp_alu);
        chk("WriteDataM", idx, bus.WriteDataM, v.rst ? 32'h0 : v.exp_wd);
        chk("PCPlus4M", idx, bus.PCPlus4M, v.rst ? 32'h0 : v.pcp4);
        chk("RdM", idx, {27'b0, bus.RdM}, v.rst ? 32'h0 : {27'b0, v.rd});
        chk("RegWriteM", idx, {31'b0, bus.RegWriteM}, v.rst ? 32'h0 : {31'b0, v.regw});
        chk("MemWriteM", idx, {31'b0, bus.MemWriteM}, v.rst ? 32'h0 : {31'b0, v.memw});
        chk("ResultSrcM", idx, {30'b0, bus.ResultSrcM}, v.rst ? 32'h0 : {30'b0, v.rsrc});
        m_alu = v.rst ? 32'h0 : v.exp_alu;
    endtask

    initial begin
        vec_t v;
        logic [31:0] sa, wd, sb, al, js;

        bus.RD1_E = 0; bus.RD2_E = 0; bus.ImmExtE = 0; bus.PCE = 0; bus.PCPlus4E = 0;
        bus.RdE = 0; bus.RegWriteE = 0; bus.MemWriteE = 0; bus.JumpE = 0; bus.jalrE = 0;
        bus.BranchE = 0; bus.ALUSrcE = 0; bus.ALUControlE = 0; bus.ResultSrcE = 0;
        bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = 0;

        // reset held two cycles with a live write pending
        v = op(3'd0, 32'd7, 32'd3, 32'd10, 32'd3); v.rst = 1; v.rd = 5'd5; tbl.push_back(v);
        tbl.push_back(v);
        // add / sub / sub wrap
        v = op(3'd0, 32'd7, 32'd3, 32'd10, 32'd3); v.rd = 5'd5; tbl.push_back(v);
        v = op(3'd1, 32'd7, 32'd3, 32'd4, 32'd3); tbl.push_back(v);
        v = op(3'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd1); tbl.push_back(v);
        // beq taken / not taken
        v = op(3'd1, 32'h20, 32'h20, 32'h0, 32'h20); v.regw = 0; v.rd = 0; v.branch = 1;
        v.pc = 32'h100; v.imm = 32'hFFFF_FFF8; v.exp_pcsrc = 1; v.exp_tgt = 32'hF8; tbl.push_back(v);
        v.rd2 = 32'h21; v.exp_pcsrc = 0; v.exp_alu = 32'hFFFF_FFFF; v.exp_wd = 32'h21; tbl.push_back(v);
        // jalr with odd sum, link data carried to M
        v = op(3'd0, 32'h1003, 32'h0, 32'h1007, 32'h0); v.jalr = 1; v.alusrc = 1; v.imm = 32'h4;
        v.rsrc = 2'b10; v.pcp4 = 32'h44; v.exp_pcsrc = 1; v.exp_tgt = 32'h1006; tbl.push_back(v);
        // back-to-back dependency through ALUResultM, store data from ResultW
        v = op(3'd0, 32'd5, 32'd6, 32'd11, 32'd6); tbl.push_back(v);
        v = op(3'd0, 32'd0, 32'h55, 32'd12, 32'hAB); v.fa = 2'b10; v.alusrc = 1; v.imm = 32'd1;
        v.fb = 2'b01; v.resw = 32'hAB; v.memw = 1; v.exp_tgt = 32'd1; tbl.push_back(v);
        // compares and shift
        v = op(3'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1); tbl.push_back(v);
        v = op(3'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1); tbl.push_back(v);
        v = op(3'd7, 32'd3, 32'd0, 32'd6, 32'd0); v.alusrc = 1; v.imm = 32'h21; v.exp_tgt = 32'h21; tbl.push_back(v);
        // select 11 falls back to register file
        v = op(3'd0, 32'd9, 32'd2, 32'd11, 32'd2); v.fa = 2'b11; v.fb = 2'b11; v.resw = 32'h100; tbl.push_back(v);
        // jump and branch together, branch not taken
        v = op(3'd1, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'd2); v.jump = 1; v.branch = 1;
        v.pc = 32'h200; v.imm = 32'h10; v.exp_pcsrc = 1; v.exp_tgt = 32'h210; tbl.push_back(v);
        // logic ops
        tbl.push_back(op(3'd2, 32'hF0F0, 32'hFF00, 32'hF000, 32'hFF00));
        tbl.push_back(op(3'd3, 32'hF0F0, 32'hFF00, 32'hFFF0, 32'hFF00));
        tbl.push_back(op(3'd4, 32'hF0F0, 32'hFF00, 32'h0FF0, 32'hFF00));
        // reset mid-stream drops the instruction, later MEM forward sees the bubble
        v = op(3'd0, 32'd1, 32'd1, 32'd2, 32'd1); v.rst = 1; tbl.push_back(v);
        v = op(3'd0, 32'd77, 32'd5, 32'd5, 32'd5); v.fa = 2'b10; tbl.push_back(v);
        // jalr with rs1 forwarded from writeback
        v = op(3'd0, 32'h0, 32'h0, 32'h2011, 32'h0); v.jalr = 1; v.alusrc = 1; v.fa = 2'b01;
        v.resw = 32'h2001; v.imm = 32'h10; v.exp_pcsrc = 1; v.exp_tgt = 32'h2010; tbl.push_back(v);
        // all-zero bubble
        v = blank(); tbl.push_back(v);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // random vectors against the reference model
        for (int i = 0; i < 400; i++) begin
            v = blank();
            v.rst    = ($urandom_range(0, 24) == 0);
            v.rd1    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            v.rd2    = ($urandom_range(0, 2) == 0) ? v.rd1 : $urandom;
            v.imm    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            v.pc     = $urandom; v.pcp4 = v.pc + 32'd4; v.resw = $urandom;
            v.rd     = 5'($urandom); v.regw = 1'($urandom); v.memw = 1'($urandom);
            v.jump   = ($urandom_range(0, 5) == 0); v.jalr = ($urandom_range(0, 5) == 0);
            v.branch = 1'($urandom); v.alusrc = 1'($urandom);
            v.ctl    = 3'($urandom); v.rsrc = 2'($urandom);
            v.fa     = 2'($urandom); v.fb = 2'($urandom);
            sa = pick(v.fa, v.rd1, v.resw, m_alu);
            wd = pick(v.fb, v.rd2, v.resw, m_alu);
            sb = v.alusrc ? v.imm : wd;
            al = ref_alu(v.ctl, sa, sb);
            js = ref_alu(3'd0, sa, v.imm);
            v.exp_pcsrc = v.jump || v.jalr || (v.branch && al == 32'd0);
            v.exp_tgt   = v.jalr ? (js - (js % 2)) : ref_alu(3'd0, v.pc, v.imm);
            v.exp_alu   = al;
            v.exp_wd    = wd;
            apply(v, 1000 + i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
